text_write_sequencer: RTL and testbench

- Sits between the I2C slave command decoder and the video memory write port.
- Accepts character-write commands and queues them in a small FIFO.
- Maintains an auto-advancing text cursor and expands a FILL command into a full-screen burst of writes.
- Drives the memory's write, xtextwrite, ytextwrite and value inputs with at most one write per clk.

---
 rtl/text_write_sequencer_pkg.sv | 17 +
 rtl/text_write_sequencer_cmd_fifo.sv | 42 ++++
 rtl/text_write_sequencer.sv | 130 +++++++++++++
 tb/tb_text_write_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_write_sequencer_pkg.sv
// text_write_sequencer_pkg: screen geometry, field widths, command opcodes and sequencer states
package text_write_sequencer_pkg;
    localparam int DEF_TEXT_COLS  = 100;
    localparam int DEF_TEXT_ROWS  = 60;
    localparam int DEF_COLS_W     = 7;
    localparam int DEF_ROWS_W     = 6;
    localparam int DEF_ATTR_W     = 20;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int CMDOP_W        = 2;
    typedef enum logic [CMDOP_W-1:0] {
        OP_WRITE_AT   = 2'd0,
        OP_WRITE_NEXT = 2'd1,
        OP_FILL       = 2'd2,
        OP_SET_CURSOR = 2'd3
    } cmd_op_t;
    typedef enum logic {IDLE, FILL} seq_state_t;
endpackage

// File: rtl/text_write_sequencer_cmd_fifo.sv
// cmd_fifo: single-clock FIFO holding packed sequencer commands; full/empty derive from registered occupancy
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_button,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/text_write_sequencer.sv
// text_write_sequencer: queues character-write commands, tracks an auto-advancing text cursor
// and expands FILL into a row-major full-screen burst, issuing at most one memory write per clk.
module text_write_sequencer
    import text_write_sequencer_pkg::*;
#(
    parameter int TEXT_COLS  = DEF_TEXT_COLS,
    parameter int TEXT_ROWS  = DEF_TEXT_ROWS,
    parameter int COLS_W     = DEF_COLS_W,
    parameter int ROWS_W     = DEF_ROWS_W,
    parameter int ATTR_W     = DEF_ATTR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset_button,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CMDOP_W-1:0] cmd_op,
    input  logic [COLS_W-1:0]  cmd_x,
    input  logic [ROWS_W-1:0]  cmd_y,
    input  logic [ATTR_W-1:0]  cmd_attr,
    output logic               write,
    output logic [COLS_W-1:0]  xtextwrite,
    output logic [ROWS_W-1:0]  ytextwrite,
    output logic [ATTR_W-1:0]  value,
    output logic               busy,
    output logic               range_error
);
    localparam int ENTRY_W = CMDOP_W + COLS_W + ROWS_W + ATTR_W;
    localparam logic [COLS_W-1:0] LAST_X = COLS_W'(TEXT_COLS - 1);
    localparam logic [ROWS_W-1:0] LAST_Y = ROWS_W'(TEXT_ROWS - 1);

    seq_state_t         state;
    logic [COLS_W-1:0]  cur_x;
    logic [ROWS_W-1:0]  cur_y;
    logic [ATTR_W-1:0]  fill_attr;
    logic               full;
    logic               empty;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [CMDOP_W-1:0] head_op;
    logic [COLS_W-1:0]  head_x;
    logic [ROWS_W-1:0]  head_y;
    logic [ATTR_W-1:0]  head_attr;
    logic               head_in_range;

    function automatic logic [ROWS_W+COLS_W-1:0] succ(input logic [COLS_W-1:0] x, input logic [ROWS_W-1:0] y);
        return (x != LAST_X) ? {y, x + COLS_W'(1)} :
               (y != LAST_Y) ? {y + ROWS_W'(1), {COLS_W{1'b0}}} : '0;
    endfunction

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk          (clk),
        .reset_button (reset_button),
        .push         (cmd_valid),
        .pop          (pop),
        .din          ({cmd_op, cmd_x, cmd_y, cmd_attr}),
        .dout         (head),
        .full         (full),
        .empty        (empty)
    );

    assign {head_op, head_x, head_y, head_attr} = head;
    assign head_in_range = (head_x <= LAST_X) && (head_y <= LAST_Y);
    assign pop       = (state == IDLE) & ~empty;
    assign cmd_ready = ~full;
    assign busy      = ~empty | (state == FILL) | write;

    // The cursor doubles as the fill scan position; its wrap after the last cell leaves it at (0,0).
    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            state       <= IDLE;
            cur_x       <= '0;
            cur_y       <= '0;
            fill_attr   <= '0;
            write       <= 1'b0;
            xtextwrite  <= '0;
            ytextwrite  <= '0;
            value       <= '0;
            range_error <= 1'b0;
        end else begin
            write <= 1'b0;
            if (state == FILL) begin
                write          <= 1'b1;
                xtextwrite     <= cur_x;
                ytextwrite     <= cur_y;
                value          <= fill_attr;
                {cur_y, cur_x} <= succ(cur_x, cur_y);
                if (cur_x == LAST_X && cur_y == LAST_Y) state <= IDLE;
            end else if (!empty) begin
                case (cmd_op_t'(head_op))
                    OP_WRITE_AT: begin
                        if (head_in_range) begin
                            write          <= 1'b1;
                            xtextwrite     <= head_x;
                            ytextwrite     <= head_y;
                            value          <= head_attr;
                            {cur_y, cur_x} <= succ(head_x, head_y);
                        end else begin
                            range_error <= 1'b1;
                        end
                    end
                    OP_WRITE_NEXT: begin
                        write          <= 1'b1;
                        xtextwrite     <= cur_x;
                        ytextwrite     <= cur_y;
                        value          <= head_attr;
                        {cur_y, cur_x} <= succ(cur_x, cur_y);
                    end
                    OP_FILL: begin
                        state     <= FILL;
                        fill_attr <= head_attr;
                        cur_x     <= '0;
                        cur_y     <= '0;
                    end
                    default: begin
                        if (head_in_range) begin
                            cur_x <= head_x;
                            cur_y <= head_y;
                        end else begin
                            range_error <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_text_write_sequencer.sv
`timescale 1ns/1ps
// tb_text_write_sequencer: randomized bench comparing the write stream against a linear-index cursor model
module tb_text_write_sequencer;
    localparam int COLS  = 100;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset_button = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [6:0]  cmd_x = '0;
    logic [5:0]  cmd_y = '0;
    logic [19:0] cmd_attr = '0;
    logic        cmd_ready;
    logic        write;
    logic [6:0]  xtextwrite;
    logic [5:0]  ytextwrite;
    logic [19:0] value;
    logic        busy;
    logic        range_error;

    typedef struct {int x; int y; int v; int t;} wr_t;
    wr_t obs[$];
    wr_t exp_q[$];
    int  m_idx = 0;
    int  m_err = 0;
    int  cyc = 0;
    int  passed = 0;
    int  total = 0;

    text_write_sequencer dut (
        .clk          (clk),
        .reset_button (reset_button),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_attr     (cmd_attr),
        .write        (write),
        .xtextwrite   (xtextwrite),
        .ytextwrite   (ytextwrite),
        .value        (value),
        .busy         (busy),
        .range_error  (range_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (reset_button === 1'b1 && write === 1'b1)
            obs.push_back('{int'(xtextwrite), int'(ytextwrite), int'(value), cyc});

    task automatic model(input int op, input int x, input int y, input int a);
        bit ok;
        ok = (x < COLS) && (y < ROWS);
        case (op)
            0: if (ok) begin exp_q.push_back('{x, y, a, 0}); m_idx = (y * COLS + x + 1) % CELLS; end else m_err = 1;
            1: begin exp_q.push_back('{m_idx % COLS, m_idx / COLS, a, 0}); m_idx = (m_idx + 1) % CELLS; end
            2: begin for (int i = 0; i < CELLS; i++) exp_q.push_back('{i % COLS, i / COLS, a, 0}); m_idx = 0; end
            default: if (ok) m_idx = y * COLS + x; else m_err = 1;
        endcase
    endtask

    task automatic clear_model();
        m_idx = 0;
        m_err = 0;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic send(input int op, input int x, input int y, input int a);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op = 2'(op);
        cmd_x = 7'(x);
        cmd_y = 6'(y);
        cmd_attr = 20'(a);
        while (cmd_ready !== 1'b1 && n < 10000) begin @(posedge clk); #1; n++; end
        if (n >= 10000) begin
            total++;
            $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        model(op, x, y, a);
        @(posedge clk); #1;
    endtask

    task automatic settle(output int bad);
        int n = 0;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        while (busy !== 1'b0 && n < 20000) begin @(posedge clk); #1; n++; end
        @(negedge clk); #2;
        bad = (n >= 20000) ? 1 : 0;
        if (obs.size() != exp_q.size()) bad++;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            if (obs[i].x != exp_q[i].x || obs[i].y != exp_q[i].y || obs[i].v != exp_q[i].v) bad++;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        @(negedge clk);
        reset_button = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_model();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_button = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (write !== 1'b0) $display("FAIL reset_write: got %b, required 0", write); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", cmd_ready); else passed++;
        total++; if (range_error !== 1'b0) $display("FAIL reset_range_error: got %b, required 0", range_error); else passed++;
        total++;
        if ({xtextwrite, ytextwrite, value} !== 33'd0)
            $display("FAIL reset_outputs: got x=%0d y=%0d v=%h, required 0/0/0", xtextwrite, ytextwrite, value);
        else passed++;
        release_reset();
    endtask

    task automatic test_write_at();
        int bad, acc;
        send(0, 5, 3, 'h12345);
        acc = cyc;
        settle(bad);
        send(1, 0, 0, 'h0ABCD);
        settle(bad);
        total++;
        if (obs.size() != 2) $display("FAIL write_at_count: got %0d writes, required 2", obs.size());
        else begin
            passed++;
            total++;
            if (obs[0].x != 5 || obs[0].y != 3 || obs[0].v != 'h12345)
                $display("FAIL write_at_cell: got (%0d,%0d,%h), required (5,3,12345)", obs[0].x, obs[0].y, obs[0].v);
            else passed++;
            total++;
            if (obs[0].t != acc + 1) $display("FAIL write_at_latency: write at edge %0d, required %0d", obs[0].t, acc + 1);
            else passed++;
            total++;
            if (obs[1].x != 6 || obs[1].y != 3) $display("FAIL write_next_after_at: got (%0d,%0d), required (6,3)", obs[1].x, obs[1].y);
            else passed++;
        end
        total++; if (bad != 0) $display("FAIL write_at_stream: %0d mismatches, required 0", bad); else passed++;
        clear_model();
    endtask

    task automatic test_wrap();
        int bad;
        m_idx = 7;
        send(3, 99, 59, 0);
        send(1, 0, 0, 'h11111);
        send(1, 0, 0, 'h22222);
        send(1, 0, 0, 'h33333);
        settle(bad);
        total++;
        if (obs.size() != 3) $display("FAIL wrap_count: got %0d writes, required 3", obs.size());
        else begin
            passed++;
            total++;
            if (obs[0].x != 99 || obs[0].y != 59 || obs[1].x != 0 || obs[1].y != 0 || obs[2].x != 1 || obs[2].y != 0)
                $display("FAIL wrap_cells: got (%0d,%0d) (%0d,%0d) (%0d,%0d), required (99,59) (0,0) (1,0)",
                         obs[0].x, obs[0].y, obs[1].x, obs[1].y, obs[2].x, obs[2].y);
            else passed++;
        end
        total++; if (bad != 0) $display("FAIL wrap_stream: %0d mismatches, required 0", bad); else passed++;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_range();
        int bad;
        send(0, 100, 0, 'h55555);
        send(3, 0, 60, 0);
        settle(bad);
        total++; if (obs.size() != 0) $display("FAIL range_no_write: got %0d writes, required 0", obs.size()); else passed++;
        total++; if (range_error !== 1'b1) $display("FAIL range_error_set: got %b, required 1", range_error); else passed++;
        repeat (20) @(posedge clk);
        #1;
        total++; if (range_error !== 1'b1) $display("FAIL range_error_sticky: got %b, required 1", range_error); else passed++;
        send(1, 0, 0, 'h77777);
        settle(bad);
        total++;
        if (obs.size() != 1 || obs[0].x != 2 || obs[0].y != 0)
            $display("FAIL range_cursor_kept: got %0d writes first at (%0d,%0d), required 1 at (2,0)",
                     obs.size(), obs.size() > 0 ? obs[0].x : -1, obs.size() > 0 ? obs[0].y : -1);
        else passed++;
        total++; if (bad != 0) $display("FAIL range_stream: %0d mismatches, required 0", bad); else passed++;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_fill();
        int bad, gaps;
        send(2, 0, 0, 'h00041);
        for (int i = 0; i < 8; i++) begin
            send(1, 0, 0, int'($urandom_range(0, 'hFFFFF)));
            if (i == 6) begin
                total++; if (cmd_ready !== 1'b1) $display("FAIL fill_ready_before_full: got %b, required 1", cmd_ready); else passed++;
            end
        end
        total++; if (cmd_ready !== 1'b0) $display("FAIL fill_ready_low: got %b, required 0", cmd_ready); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL fill_busy: got %b, required 1", busy); else passed++;
        settle(bad);
        total++; if (bad != 0) $display("FAIL fill_stream: %0d mismatches (obs %0d, exp %0d), required 0", bad, obs.size(), exp_q.size()); else passed++;
        total++;
        if (obs.size() != CELLS + 8) $display("FAIL fill_count: got %0d writes, required %0d", obs.size(), CELLS + 8);
        else begin
            passed++;
            gaps = 0;
            for (int i = 0; i < CELLS; i++) if (obs[i].t != obs[0].t + i) gaps++;
            total++; if (gaps != 0) $display("FAIL fill_consecutive: got %0d gaps, required 0", gaps); else passed++;
            total++;
            if (obs[CELLS].x != 0 || obs[CELLS].y != 0)
                $display("FAIL fill_queued_start: got (%0d,%0d), required (0,0)", obs[CELLS].x, obs[CELLS].y);
            else passed++;
        end
        total++; if (cmd_ready !== 1'b1) $display("FAIL fill_ready_after: got %b, required 1", cmd_ready); else passed++;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int bad, gaps, sx, sy;
        sx = int'($urandom_range(0, COLS - 1));
        sy = int'($urandom_range(0, ROWS - 1));
        send(3, sx, sy, 0);
        for (int i = 0; i < 12; i++) send(1, 0, 0, int'($urandom_range(0, 'hFFFFF)));
        settle(bad);
        total++; if (bad != 0) $display("FAIL b2b_stream: %0d mismatches (obs %0d, exp %0d), required 0", bad, obs.size(), exp_q.size()); else passed++;
        total++;
        if (obs.size() != 12) $display("FAIL b2b_count: got %0d writes, required 12", obs.size());
        else begin
            passed++;
            gaps = 0;
            for (int i = 1; i < 12; i++) if (obs[i].t != obs[i - 1].t + 1) gaps++;
            total++; if (gaps != 0) $display("FAIL b2b_rate: got %0d gaps, required 0", gaps); else passed++;
            total++;
            if (obs[0].x != sx || obs[0].y != sy) $display("FAIL b2b_start: got (%0d,%0d), required (%0d,%0d)", obs[0].x, obs[0].y, sx, sy);
            else passed++;
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int bad, r, op;
        do_reset();
        release_reset();
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            op = (r < 3) ? 0 : (r < 7) ? 1 : (r < 9) ? 3 : 1;
            send(op, int'($urandom_range(0, 110)), int'($urandom_range(0, 63)), int'($urandom_range(0, 'hFFFFF)));
            if ($urandom_range(0, 3) == 0) begin cmd_valid = 1'b0; @(posedge clk); #1; end
        end
        settle(bad);
        total++; if (bad != 0) $display("FAIL random_stream: %0d mismatches (obs %0d, exp %0d), required 0", bad, obs.size(), exp_q.size()); else passed++;
        total++; if (range_error !== 1'(m_err)) $display("FAIL random_range_error: got %b, required %0d", range_error, m_err); else passed++;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_fill();
        int bad, n, mism;
        send(2, 0, 0, 'h2AAAA);
        cmd_valid = 1'b0;
        n = 0;
        while (obs.size() < 100 && n < 2000) begin @(negedge clk); #2; n++; end
        total++; if (obs.size() < 100) $display("FAIL midfill_progress: got %0d writes, required 100", obs.size()); else passed++;
        reset_button = 1'b0;
        #1;
        total++; if (write !== 1'b0) $display("FAIL midfill_write_drop: got %b, required 0", write); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midfill_busy: got %b, required 0", busy); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL midfill_ready: got %b, required 1", cmd_ready); else passed++;
        mism = 0;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            if (obs[i].x != exp_q[i].x || obs[i].y != exp_q[i].y || obs[i].v != exp_q[i].v) mism++;
        total++; if (mism != 0) $display("FAIL midfill_prefix: %0d mismatches, required 0", mism); else passed++;
        repeat (2) @(posedge clk);
        clear_model();
        release_reset();
        send(1, 0, 0, 'h0BEEF);
        settle(bad);
        total++;
        if (obs.size() != 1 || obs[0].x != 0 || obs[0].y != 0 || obs[0].v != 'h0BEEF)
            $display("FAIL midfill_restart: got %0d writes first at (%0d,%0d), required 1 at (0,0) value 0BEEF",
                     obs.size(), obs.size() > 0 ? obs[0].x : -1, obs.size() > 0 ? obs[0].y : -1);
        else passed++;
        total++; if (bad != 0) $display("FAIL midfill_stream: %0d mismatches, required 0", bad); else passed++;
        clear_model();
    endtask

    initial begin
        test_reset();
        test_write_at();
        test_wrap();
        test_range();
        test_fill();
        test_back_to_back();
        test_random();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
